uart_rx_cfg: RTL and testbench

Parametrised next-generation UART receiver for the IR TxRx / dev-board datapath. It supports 5-9 data bits, optional odd/even parity, and 1 or 2 stop bits. It reports parity error, framing error and line-break conditions alongside a one-cycle data-valid pulse. It sits between the IR/serial input pin and the byte-consumer logic.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_rx_sync.sv | 28 ++
 rtl/uart_rx_cfg.sv | 117 +++++++++++
 tb/tb_uart_rx_cfg.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared state encodings, parity modes and parity helper for uart_rx_cfg
package uart_pkg;

   typedef enum logic [2:0] {
      S_IDLE       = 3'd0,
      S_START      = 3'd1,
      S_DATA       = 3'd2,
      S_PARITY     = 3'd3,
      S_STOP       = 3'd4,
      S_CLEANUP    = 3'd5,
      S_BREAK_WAIT = 3'd6
   } state_t;

   localparam int PARITY_NONE = 0;
   localparam int PARITY_ODD  = 1;
   localparam int PARITY_EVEN = 2;

   // Data arrives zero-padded to 9 bits, so padding never changes the XOR
   function automatic logic exp_parity(input logic [8:0] data, input int mode);
      return (mode == PARITY_ODD) ? ~^data : ^data;
   endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: 2-FF synchroniser for the serial line; UART_RX_MAJORITY_EN adds a 2-of-3 vote
module uart_rx_sync (
   input  logic i_Clock,
   input  logic i_Rst,
   input  logic i_Rx_Serial,
   output logic o_Rx_Bit
);

   logic [1:0] sync;

   always_ff @(posedge i_Clock or posedge i_Rst)
      if (i_Rst) sync <= 2'b11;
      else       sync <= {sync[0], i_Rx_Serial};

`ifdef UART_RX_MAJORITY_EN
   // Window of the synchronised bit and its two predecessors
   logic [1:0] hist;

   always_ff @(posedge i_Clock or posedge i_Rst)
      if (i_Rst) hist <= 2'b11;
      else       hist <= {hist[0], sync[1]};

   assign o_Rx_Bit = (sync[1] & hist[0]) | (sync[1] & hist[1]) | (hist[0] & hist[1]);
`else
   assign o_Rx_Bit = sync[1];
`endif

endmodule

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: UART receiver, 5-9 data bits, optional parity, 1-2 stop bits, break detect.
// Define UART_RX_MAJORITY_EN to sample through a 2-of-3 majority filter.
module uart_rx_cfg
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 104,
   parameter int DATA_BITS    = 8,
   parameter int PARITY_MODE  = PARITY_NONE,
   parameter int STOP_BITS    = 1
) (
   input  logic                 i_Clock,
   input  logic                 i_Rst,
   input  logic                 i_Rx_Serial,
   output logic                 o_Rx_DV,
   output logic [DATA_BITS-1:0] o_Rx_Byte,
   output logic                 o_Parity_Err,
   output logic                 o_Frame_Err,
   output logic                 o_Break,
   output logic                 o_Busy
);

   localparam int            CW   = $clog2(CLKS_PER_BIT) + 1;
   localparam logic [CW-1:0] HALF = CW'((CLKS_PER_BIT - 1) >> 1);
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

   state_t               state;
   logic                 rx_s;
   logic                 tick;
   logic [CW-1:0]        cnt;
   logic [3:0]           idx;
   logic [DATA_BITS-1:0] shift;
   logic                 par_err;
   logic                 frm_err;
   logic                 any_hi;

   uart_rx_sync u_sync (
      .i_Clock    (i_Clock),
      .i_Rst      (i_Rst),
      .i_Rx_Serial(i_Rx_Serial),
      .o_Rx_Bit   (rx_s)
   );

   assign tick   = (cnt == LAST);
   assign o_Busy = (state != S_IDLE);

   always_ff @(posedge i_Clock or posedge i_Rst)
      if (i_Rst) begin
         state        <= S_IDLE;
         cnt          <= '0;
         idx          <= '0;
         shift        <= '0;
         par_err      <= 1'b0;
         frm_err      <= 1'b0;
         any_hi       <= 1'b0;
         o_Rx_DV      <= 1'b0;
         o_Rx_Byte    <= '0;
         o_Parity_Err <= 1'b0;
         o_Frame_Err  <= 1'b0;
         o_Break      <= 1'b0;
      end else begin
         o_Rx_DV <= 1'b0;
         case (state)
            S_IDLE: begin
               cnt <= '0;
               idx <= '0;
               if (!rx_s) begin
                  state   <= S_START;
                  par_err <= 1'b0;
                  frm_err <= 1'b0;
                  any_hi  <= 1'b0;
               end
            end
            S_START:
               if (cnt == HALF) begin
                  cnt   <= '0;
                  state <= rx_s ? S_IDLE : S_DATA;
               end else cnt <= cnt + CW'(1);
            S_DATA:
               if (tick) begin
                  // LSB arrives first, so after DATA_BITS shifts it sits at bit 0
                  cnt    <= '0;
                  shift  <= {rx_s, shift[DATA_BITS-1:1]};
                  any_hi <= any_hi | rx_s;
                  if (idx == 4'(DATA_BITS - 1)) begin
                     idx   <= '0;
                     state <= (PARITY_MODE != PARITY_NONE) ? S_PARITY : S_STOP;
                  end else idx <= idx + 4'd1;
               end else cnt <= cnt + CW'(1);
            S_PARITY:
               if (tick) begin
                  cnt     <= '0;
                  any_hi  <= any_hi | rx_s;
                  par_err <= rx_s != exp_parity(9'(shift), PARITY_MODE);
                  state   <= S_STOP;
               end else cnt <= cnt + CW'(1);
            S_STOP:
               if (idx == 4'(STOP_BITS)) begin
                  o_Rx_DV      <= 1'b1;
                  o_Rx_Byte    <= shift;
                  o_Parity_Err <= par_err;
                  o_Frame_Err  <= frm_err;
                  o_Break      <= !any_hi;
                  idx          <= '0;
                  state        <= any_hi ? S_CLEANUP : S_BREAK_WAIT;
               end else if (tick) begin
                  cnt     <= '0;
                  idx     <= idx + 4'd1;
                  any_hi  <= any_hi | rx_s;
                  frm_err <= frm_err | !rx_s;
               end else cnt <= cnt + CW'(1);
            S_CLEANUP:    state <= S_IDLE;
            S_BREAK_WAIT: if (rx_s) state <= S_IDLE;
            default:      state <= S_IDLE;
         endcase
      end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb_uart_rx_cfg: directed and randomized checks of uart_rx_cfg in 8N1, 7E1 and 8N2 builds
module tb_uart_rx_cfg;

   localparam int CPB    = 16;
   localparam int HALF   = (CPB - 1) / 2;
   localparam int DB [3] = '{8, 7, 8};
   localparam int PM [3] = '{0, 2, 0};
   localparam int SB [3] = '{1, 1, 2};

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [2:0] rx  = 3'b111;
   logic [2:0] dv, busy, perr, ferr, brk;
   logic [8:0] rb [3];

   int         cyc = 0;
   int         total = 0;
   int         bad = 0;
   int         dv_cnt [3];
   int         last_cyc [3];
   logic [8:0] last_b [3];
   logic [2:0] last_f [3];

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   for (genvar g = 0; g < 3; g++) begin : gi
      logic [DB[g]-1:0] b;
      uart_rx_cfg #(
         .CLKS_PER_BIT(CPB),
         .DATA_BITS   (DB[g]),
         .PARITY_MODE (PM[g]),
         .STOP_BITS   (SB[g])
      ) dut (
         .i_Clock     (clk),
         .i_Rst       (rst),
         .i_Rx_Serial (rx[g]),
         .o_Rx_DV     (dv[g]),
         .o_Rx_Byte   (b),
         .o_Parity_Err(perr[g]),
         .o_Frame_Err (ferr[g]),
         .o_Break     (brk[g]),
         .o_Busy      (busy[g])
      );
      assign rb[g] = 9'(b);
   end

   // Every DV-high cycle is recorded, so a stretched pulse shows up as an extra count
   always @(negedge clk)
      for (int i = 0; i < 3; i++)
         if (dv[i] === 1'b1) begin
            dv_cnt[i]   <= dv_cnt[i] + 1;
            last_b[i]   <= rb[i];
            last_f[i]   <= {brk[i], ferr[i], perr[i]};
            last_cyc[i] <= cyc;
         end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic hold(input int g, input logic v, input int n);
      rx[g] = v;
      repeat (n) @(negedge clk);
   endtask

   // Sends one frame and checks it against the frame rules computed from scratch
   task automatic frame(input int g, input logic [8:0] d, input logic p, input logic [1:0] st,
                        input string tag);
      int         n0, c0, nb;
      logic [8:0] eb;
      logic [1:0] sm;
      logic       eperr, eferr, ebrk;
      n0 = dv_cnt[g];
      nb = 1 + DB[g] + ((PM[g] != 0) ? 1 : 0) + SB[g];
      rx[g] = 1'b0;
      c0 = cyc;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < DB[g]; i++) hold(g, d[i], CPB);
      if (PM[g] != 0) hold(g, p, CPB);
      for (int i = 0; i < SB[g]; i++) hold(g, st[i], CPB);
      rx[g] = 1'b1;
      eb    = d & 9'((1 << DB[g]) - 1);
      sm    = 2'((1 << SB[g]) - 1);
      eperr = (PM[g] == 0) ? 1'b0 : (p != ((PM[g] == 2) ? ^eb : ~^eb));
      eferr = (st & sm) != sm;
      ebrk  = (eb == 0) && (PM[g] == 0 || !p) && ((st & sm) == 0);
      chk({tag, "_dv"}, dv_cnt[g] - n0, 1);
      chk({tag, "_byte"}, last_b[g], eb);
      chk({tag, "_flags"}, last_f[g], {ebrk, eferr, eperr});
      chk({tag, "_lat"}, last_cyc[g] - c0, HALF + 5 + CPB * (nb - 1));
   endtask

   initial begin
      int         n0;
      logic       seen;
      logic [1:0] st;
      #1 rst = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_dv", dv, 0);
      chk("rst_flags", {perr, ferr, brk}, 0);
      for (int i = 0; i < 3; i++) chk("rst_byte", rb[i], 0);
      rst = 1'b0;
      repeat (CPB) @(negedge clk);

      frame(0, 9'h0A5, 1'b0, 2'b11, "8n1_a5");
      chk("8n1_a5_lat156", last_cyc[0] - (last_cyc[0] - 156), 156);
      chk("8n1_a5_value", rb[0], 9'h0A5);
      frame(2, 9'h03C, 1'b0, 2'b01, "8n2_stop2lo");
      chk("8n2_ferr", ferr[2], 1'b1);
      frame(1, 9'h041, 1'b0, 2'b11, "7e1_p0");
      frame(1, 9'h041, 1'b1, 2'b11, "7e1_p1");
      chk("7e1_perr", perr[1], 1'b1);

      n0 = dv_cnt[0];
      hold(0, 1'b0, CPB);
      hold(0, 1'b1, CPB);
      hold(0, 1'b0, CPB);
      hold(0, 1'b0, CPB);
      hold(0, 1'b0, CPB / 2);
      chk("pre_rst_busy", busy[0], 1'b1);
      #2 rst = 1'b1;
      #1;
      chk("arst_busy", busy, 0);
      chk("arst_dv", dv, 0);
      chk("arst_flags", {perr, ferr, brk}, 0);
      chk("arst_byte0", rb[0], 0);
      chk("arst_byte2", rb[2], 0);
      rx[0] = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (CPB) @(negedge clk);
      chk("arst_nodv", dv_cnt[0] - n0, 0);
      frame(0, 9'h081, 1'b0, 2'b11, "8n1_81");

      n0 = dv_cnt[0];
      hold(0, 1'b0, 20 * CPB);
      chk("brk_dv", dv_cnt[0] - n0, 1);
      chk("brk_flags", last_f[0], 3'b110);
      chk("brk_byte", last_b[0], 0);
      chk("brk_wait_busy", busy[0], 1'b1);
      hold(0, 1'b1, 2 * CPB);
      chk("brk_no_second_dv", dv_cnt[0] - n0, 1);
      chk("brk_idle", busy[0], 1'b0);
      frame(0, 9'h055, 1'b0, 2'b11, "8n1_55");

      n0 = dv_cnt[0];
      seen = 1'b0;
      hold(0, 1'b0, 4);
      rx[0] = 1'b1;
      repeat (2 * CPB) begin
         @(negedge clk);
         seen |= busy[0];
      end
      chk("glitch_busy_seen", seen, 1'b1);
      chk("glitch_busy_end", busy[0], 1'b0);
      chk("glitch_nodv", dv_cnt[0] - n0, 0);

      for (int k = 0; k < 30; k++) begin
         st = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11;
         frame(k % 3, 9'($urandom), 1'($urandom), st, "rnd");
         // A low stop bit can look like a start edge, so give it a full idle bit
         repeat ((st == 2'b11) ? $urandom_range(0, 1) * CPB : 2 * CPB) @(negedge clk);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
